// File: rtl/interrupt_dispatcher.sv
// rtl/interrupt_dispatcher.sv - arbitrates pending interrupt flags to the CPU over req/ack and returns RETI
//
// Sits downstream of the per-source interrupt request buffers. One source at a
// time is offered to the CPU. The source it accepts is tracked until the CPU
// signals RETI, and that RETI is then returned to the source's buffer as a
// one-cycle read pulse. Every output is registered.
//
// Optional feature macro: IRQ_ROUND_ROBIN_EN
//   defined   : rotating priority. The search starts after the last serviced source.
//   undefined : fixed priority. Index 0 is the highest.
//
// Parameters
//   NUM_SRC   number of interrupt sources
//   ID_W      width of irq_id (2**ID_W >= NUM_SRC)
//   TIMEOUT   SERVICE cycles before irq_timeout is set; 0 disables the watchdog
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   int_flag       pending flags from the request buffers (level)
//   global_ie      global interrupt enable
//   irq_req        request to the CPU, held until accepted
//   irq_id         source index of the current request or service
//   irq_ack        CPU accepts the request
//   cpu_reti       CPU finished the ISR (1-cycle pulse)
//   handling       one-hot, the bit of the in-service source is set
//   reti_o         one-hot 1-cycle pulse to the serviced source's buffer
//   spurious_reti  1-cycle pulse when cpu_reti arrives outside SERVICE
//   irq_timeout    sticky watchdog expiry flag, cleared only by rst

module interrupt_dispatcher #(
  parameter int NUM_SRC = 3,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] int_flag,
  input  logic               global_ie,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               cpu_reti,
  output logic [NUM_SRC-1:0] handling,
  output logic [NUM_SRC-1:0] reti_o,
  output logic               spurious_reti,
  output logic               irq_timeout
);

  // With TIMEOUT=0 the counter is never used. It is kept 1 bit wide so that
  // the declaration stays legal.
  localparam int             WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE,
    S_RETI,
    S_GUARD
  } state_t;

  state_t             state, state_nxt;
  logic               req_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [NUM_SRC-1:0] hand_nxt;
  logic [NUM_SRC-1:0] reti_nxt;
  logic               spur_nxt;
  logic               to_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_nxt;

  logic [ID_W-1:0]    winner;
  logic               win_found;
  logic               cur_flag;
  logic [NUM_SRC-1:0] id_onehot;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    last_srv, last_srv_nxt;
`endif

  // Priority search. In rotating mode, the first pass looks only above the
  // last serviced index. The second pass wraps around to index 0. Together
  // the two passes give a search that starts at (last+1) mod NUM_SRC.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && int_flag[i] && (i > int'(last_srv))) begin
        winner    = ID_W'(i);
        win_found = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!win_found && int_flag[i]) begin
        winner    = ID_W'(i);
        win_found = 1'b1;
      end
    end
  end

  // Flag of the requested source, and irq_id decoded to one-hot. The decode
  // compares against each index, so an irq_id beyond NUM_SRC-1 can never
  // index outside int_flag.
  always_comb begin
    cur_flag  = 1'b0;
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (irq_id == ID_W'(i)) begin
        cur_flag     = int_flag[i];
        id_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    req_nxt   = irq_req;
    id_nxt    = irq_id;
    hand_nxt  = handling;
    reti_nxt  = '0;
    spur_nxt  = cpu_reti && (state != S_SERVICE);
    wd_nxt    = wd_cnt;
    to_nxt    = irq_timeout;
`ifdef IRQ_ROUND_ROBIN_EN
    last_srv_nxt = last_srv;
`endif

    case (state)
      S_IDLE: begin
        if (global_ie && (|int_flag)) begin
          state_nxt = S_REQ;
          req_nxt   = 1'b1;
          id_nxt    = winner;
        end
      end

      // Ack takes precedence over a flag that falls in the same cycle.
      // global_ie is deliberately not looked at here: once a request is
      // raised, only a withdrawn flag or an ack ends it.
      S_REQ: begin
        if (irq_ack) begin
          state_nxt = S_SERVICE;
          req_nxt   = 1'b0;
          hand_nxt  = id_onehot;
          wd_nxt    = '0;
        end else if (!cur_flag) begin
          state_nxt = S_IDLE;
          req_nxt   = 1'b0;
        end
      end

      S_SERVICE: begin
        if (TIMEOUT != 0 && wd_cnt != WD_MAX) begin
          wd_nxt = wd_cnt + 1'b1;
          if (wd_nxt == WD_MAX) begin
            to_nxt = 1'b1;
          end
        end
        if (cpu_reti) begin
          state_nxt = S_RETI;
          hand_nxt  = '0;
          reti_nxt  = id_onehot;
`ifdef IRQ_ROUND_ROBIN_EN
          last_srv_nxt = irq_id;
`endif
        end
      end

      S_RETI: begin
        state_nxt = S_GUARD;
      end

      // One idle cycle gives the buffer's empty flag time to follow the read
      // pulse, so the same request is not dispatched twice.
      S_GUARD: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        hand_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_req       <= 1'b0;
      irq_id        <= '0;
      handling      <= '0;
      reti_o        <= '0;
      spurious_reti <= 1'b0;
      irq_timeout   <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      irq_req       <= req_nxt;
      irq_id        <= id_nxt;
      handling      <= hand_nxt;
      reti_o        <= reti_nxt;
      spurious_reti <= spur_nxt;
      irq_timeout   <= to_nxt;
      wd_cnt        <= wd_nxt;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Reset to the top index, so that source 0 wins the first search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_srv <= ID_W'(NUM_SRC - 1);
    end else begin
      last_srv <= last_srv_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb/tb_interrupt_dispatcher.sv - directed self-checking bench for interrupt_dispatcher
module tb_interrupt_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] int_flag;
  logic       global_ie;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic       cpu_reti;
  logic [2:0] handling;
  logic [2:0] reti_o;
  logic       spurious_reti;
  logic       irq_timeout;

  int checks = 0;
  int errors = 0;

`ifdef IRQ_ROUND_ROBIN_EN
  int exp_order[4] = '{0, 1, 2, 0};
`else
  int exp_order[4] = '{0, 0, 0, 0};
`endif

  interrupt_dispatcher #(
    .NUM_SRC(3),
    .ID_W(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .int_flag(int_flag),
    .global_ie(global_ie),
    .irq_req(irq_req),
    .irq_id(irq_id),
    .irq_ack(irq_ack),
    .cpu_reti(cpu_reti),
    .handling(handling),
    .reti_o(reti_o),
    .spurious_reti(spurious_reti),
    .irq_timeout(irq_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(irq_req), 0);
    check({tag, "_id"}, 32'(irq_id), 0);
    check({tag, "_handling"}, 32'(handling), 0);
    check({tag, "_reti_o"}, 32'(reti_o), 0);
    check({tag, "_spurious"}, 32'(spurious_reti), 0);
    check({tag, "_timeout"}, 32'(irq_timeout), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    int_flag  = '0;
    global_ie = 1'b0;
    irq_ack   = 1'b0;
    cpu_reti  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    global_ie = 1'b1;

    // Single source 1, full handshake.
    int_flag = 3'b010;
    tick();
    check("single_req", 32'(irq_req), 1);
    check("single_id", 32'(irq_id), 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("single_handling", 32'(handling), 32'b010);
    check("single_req_drop", 32'(irq_req), 0);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    int_flag = 3'b000;
    check("single_reti", 32'(reti_o), 32'b010);
    check("single_handling_drop", 32'(handling), 0);
    tick();
    check("single_guard_reti", 32'(reti_o), 0);
    check("single_guard_req", 32'(irq_req), 0);
    tick();
    check("single_idle_req", 32'(irq_req), 0);
    check("single_no_spurious", 32'(spurious_reti), 0);

    // All three flags set: service order depends on the priority mode.
    do_reset();
    int_flag = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("multi_req", 32'(irq_req), 1);
      check("multi_id", 32'(irq_id), 32'(exp_order[k]));
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("multi_handling", 32'(handling), 32'(1) << exp_order[k]);
      cpu_reti = 1'b1;
      tick();
      cpu_reti = 1'b0;
      check("multi_reti", 32'(reti_o), 32'(1) << exp_order[k]);
      tick();
      check("multi_guard", 32'(reti_o), 0);
      tick();
    end
    int_flag = 3'b000;
    tick();

    // Withdraw: flag 2 drops before ack.
    int_flag = 3'b100;
    tick();
    check("wd_req", 32'(irq_req), 1);
    check("wd_id", 32'(irq_id), 2);
    int_flag = 3'b000;
    tick();
    check("wd_req_drop", 32'(irq_req), 0);
    check("wd_no_reti", 32'(reti_o), 0);
    tick();
    check("wd_idle_req", 32'(irq_req), 0);
    check("wd_idle_handling", 32'(handling), 0);

    // Ack and flag drop in the same cycle: ack wins.
    int_flag = 3'b001;
    tick();
    check("race_req", 32'(irq_req), 1);
    irq_ack  = 1'b1;
    int_flag = 3'b000;
    tick();
    irq_ack = 1'b0;
    check("race_handling", 32'(handling), 32'b001);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    check("race_reti", 32'(reti_o), 32'b001);
    tick();
    tick();

    // global_ie falling during REQ keeps the request.
    int_flag = 3'b010;
    tick();
    global_ie = 1'b0;
    tick();
    check("ie_drop_req_held", 32'(irq_req), 1);
    check("ie_drop_id", 32'(irq_id), 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ie_drop_handling", 32'(handling), 32'b010);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    int_flag = 3'b000;
    check("ie_drop_reti", 32'(reti_o), 32'b010);
    tick();
    tick();

    // Spurious RETI while in IDLE.
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    check("spurious_pulse", 32'(spurious_reti), 1);
    check("spurious_no_reti", 32'(reti_o), 0);
    tick();
    check("spurious_clear", 32'(spurious_reti), 0);

    // Interrupts globally disabled: no request for 100 cycles.
    int_flag = 3'b001;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("ie_off_req", 32'(irq_req), 0);
    end
    int_flag  = 3'b000;
    global_ie = 1'b1;
    tick();

    // Watchdog with TIMEOUT=8, then reset in the middle of the service.
    int_flag = 3'b001;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("wdog_handling", 32'(handling), 32'b001);
    for (int k = 0; k < 7; k++) tick();
    check("wdog_not_yet", 32'(irq_timeout), 0);
    tick();
    check("wdog_expired", 32'(irq_timeout), 1);
    check("wdog_still_service", 32'(handling), 32'b001);
    tick();
    check("wdog_sticky", 32'(irq_timeout), 1);
    int_flag = 3'b000;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    check("rst_no_reti", 32'(reti_o), 0);
    rst = 1'b0;
    tick();
    check("post_rst_reti", 32'(reti_o), 0);
    check("post_rst_timeout", 32'(irq_timeout), 0);
    check("post_rst_req", 32'(irq_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
